// File: rtl/wb_dual_master_arbiter.sv
// Two-master arbiter in front of one single-beat classic Wishbone slave.
// One transfer per grant; a grant that never sees s_ack is aborted with an error.
module wb_dual_master_arbiter #(
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic [1:0]  dbg_state
);

  // Handshake: a master request is valid while cyc & stb are high; it completes
  // in the cycle its ack (or err) is high, and the master must hold it stable until then.

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant, last_grant_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            req0, req1, own1, own_cyc, own_stb, timeout;

  assign req0      = m0_cyc & m0_stb;
  assign req1      = m1_cyc & m1_stb;
  assign own1      = (state == OWN1);
  assign own_cyc   = own1 ? m1_cyc : m0_cyc;
  assign own_stb   = own1 ? m1_stb : m0_stb;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    timeout        = 1'b0;
    s_cyc          = 1'b0;
    s_stb          = 1'b0;
    s_we           = 1'b0;
    s_sel          = 4'd0;
    s_addr         = 32'd0;
    s_wdata        = 32'd0;
    grant          = 2'b00;
    m0_ack         = 1'b0;
    m0_err         = 1'b0;
    m0_rdata       = 32'd0;
    m1_ack         = 1'b0;
    m1_err         = 1'b0;
    m1_rdata       = 32'd0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // Round-robin hands the tie to whichever master was not served last.
          state_nxt = ((PRIORITY_MODE != 0) || !last_grant) ? OWN1 : OWN0;
        end else if (req0) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST) && !s_ack;
        s_cyc   = own_cyc & ~timeout;
        s_stb   = own_stb & ~timeout;
        s_we    = own1 ? m1_we    : m0_we;
        s_sel   = own1 ? m1_sel   : m0_sel;
        s_addr  = own1 ? m1_addr  : m0_addr;
        s_wdata = own1 ? m1_wdata : m0_wdata;
        grant   = own1 ? 2'b10 : 2'b01;
        if (own1) begin
          m1_ack   = s_ack & m1_cyc;
          m1_err   = timeout;
          m1_rdata = s_rdata;
        end else begin
          m0_ack   = s_ack & m0_cyc;
          m0_err   = timeout;
          m0_rdata = s_rdata;
        end
        if (s_ack || !own_cyc || timeout) begin
          state_nxt      = IDLE;
          last_grant_nxt = own1;
          cnt_nxt        = '0;
        end else if (cnt != {CW{1'b1}}) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share stimulus.
module tb_wb_dual_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  grant, dbg_state;

  logic [31:0] m0_rdata_p, m1_rdata_p, s_addr_p, s_wdata_p;
  logic        m0_ack_p, m0_err_p, m1_ack_p, m1_err_p, s_cyc_p, s_stb_p, s_we_p;
  logic [3:0]  s_sel_p;
  logic [1:0]  grant_p, dbg_state_p;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_dual_master_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .dbg_state(dbg_state)
  );

  wb_dual_master_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata_p),
    .m0_ack(m0_ack_p), .m0_err(m0_err_p),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata_p),
    .m1_ack(m1_ack_p), .m1_err(m1_err_p),
    .s_cyc(s_cyc_p), .s_stb(s_stb_p), .s_we(s_we_p), .s_sel(s_sel_p),
    .s_addr(s_addr_p), .s_wdata(s_wdata_p), .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant_p), .dbg_state(dbg_state_p)
  );

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
    s_ack = 0; s_rdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_addr = 32'hAAAA_0000; m0_wdata = 32'h5555;
    s_ack = 1; s_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({s_cyc, s_stb, s_we, s_sel} !== 7'd0) begin failures++;
      $display("FAIL reset_slave_ctl: got %b expected 0", {s_cyc, s_stb, s_we, s_sel}); end
    checks++; if ({s_addr, s_wdata} !== 64'd0) begin failures++;
      $display("FAIL reset_slave_data: got %h expected 0", {s_addr, s_wdata}); end
    checks++; if ({grant, m0_ack, m0_err, m1_ack, m1_err} !== 6'd0) begin failures++;
      $display("FAIL reset_grant_ack: got %b expected 0", {grant, m0_ack, m0_err, m1_ack, m1_err}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin failures++;
      $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); end
    checks++; if (dbg_state !== 2'd0) begin failures++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    apply_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_addr = 32'h0000_0010;
    @(negedge clk);
    checks++; if ({grant, s_stb} !== 3'b000) begin failures++;
      $display("FAIL read_arb_cycle: got grant=%b stb=%b expected 00/0", grant, s_stb); end
    next_cycle();
    @(negedge clk);
    checks++; if ({grant, s_stb, s_cyc, m0_ack} !== 5'b01110) begin failures++;
      $display("FAIL read_wait: got %b expected 01110", {grant, s_stb, s_cyc, m0_ack}); end
    checks++; if (s_addr !== 32'h0000_0010) begin failures++;
      $display("FAIL read_addr: got %h expected 00000010", s_addr); end
    next_cycle();
    s_ack = 1; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL read_ack: got ack=%b rdata=%h expected 1/deadbeef", m0_ack, m0_rdata); end
    checks++; if ({m1_ack, m1_err, m1_rdata} !== 34'd0) begin failures++;
      $display("FAIL read_m1_quiet: got %h expected 0", {m1_ack, m1_err, m1_rdata}); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++; if ({grant, m0_ack, m0_rdata} !== 35'd0 || dbg_state !== 2'd0) begin failures++;
      $display("FAIL read_back_idle: got grant=%b ack=%b state=%0d expected 00/0/0", grant, m0_ack, dbg_state); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rr;
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      s_ack = 0;
      @(negedge clk);
      checks++; if ({grant, grant_p} !== 4'b0000) begin failures++;
        $display("FAIL b2b_idle[%0d]: got rr=%b fp=%b expected 00/00", i, grant, grant_p); end
      next_cycle();
      s_ack = 1; s_rdata = 32'h1000 + i;
      exp_rr = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (grant !== exp_rr) begin failures++;
        $display("FAIL b2b_rr_grant[%0d]: got %b expected %b", i, grant, exp_rr); end
      checks++; if ({m1_ack, m0_ack} !== exp_rr) begin failures++;
        $display("FAIL b2b_rr_ack[%0d]: got %b expected %b", i, {m1_ack, m0_ack}, exp_rr); end
      checks++; if (grant_p !== 2'b10 || m1_ack_p !== 1'b1) begin failures++;
        $display("FAIL b2b_fp_grant[%0d]: got %b ack=%b expected 10/1", i, grant_p, m1_ack_p); end
      next_cycle();
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    checks++; if (grant_p !== 2'b00) begin failures++;
      $display("FAIL fp_m0_idle: got %b expected 00", grant_p); end
    next_cycle();
    s_ack = 1;
    @(negedge clk);
    checks++; if (grant_p !== 2'b01 || m0_ack_p !== 1'b1 || grant !== 2'b01) begin failures++;
      $display("FAIL fp_m0_served: got fp=%b ack=%b rr=%b expected 01/1/01", grant_p, m0_ack_p, grant); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_timeout();
    apply_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011; m1_addr = 32'h100; m1_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin failures++;
      $display("FAIL to_arb: got %b expected 00", grant); end
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h200;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checks++; if ({grant, s_stb, s_cyc, m1_err, m0_ack} !== 6'b101100) begin failures++;
        $display("FAIL to_wait[%0d]: got %b expected 101100", k, {grant, s_stb, s_cyc, m1_err, m0_ack}); end
      if (k == 1) begin
        checks++; if ({s_we, s_sel, s_addr, s_wdata} !== {1'b1, 4'b0011, 32'h100, 32'h1234_5678}) begin
          failures++; $display("FAIL to_write_fields: got %b %b %h %h", s_we, s_sel, s_addr, s_wdata); end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if ({m1_err, s_stb, s_cyc, m1_ack} !== 4'b1000) begin failures++;
      $display("FAIL to_err: got err/stb/cyc/ack=%b expected 1000", {m1_err, s_stb, s_cyc, m1_ack}); end
    next_cycle();
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || m1_err !== 1'b0) begin failures++;
      $display("FAIL to_idle: got grant=%b err=%b expected 00/0", grant, m1_err); end
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b01 || s_addr !== 32'h200) begin failures++;
      $display("FAIL to_m0_next: got grant=%b addr=%h expected 01/00000200", grant, s_addr); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_ack_beats_timeout();
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h300;
    next_cycle();
    for (int k = 1; k <= 7; k++) next_cycle();
    s_ack = 1; s_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++; if ({m0_ack, m0_err, s_stb} !== 3'b101 || m0_rdata !== 32'h0BAD_F00D) begin failures++;
      $display("FAIL ack_vs_timeout: got ack/err/stb=%b rdata=%h expected 101/0badf00d", {m0_ack, m0_err, s_stb}, m0_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_abort();
    apply_reset();
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h40;
    next_cycle();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++; if (grant !== 2'b01 || m0_ack !== 1'b0) begin failures++;
        $display("FAIL abort_wait[%0d]: got grant=%b ack=%b expected 01/0", k, grant, m0_ack); end
      next_cycle();
    end
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    checks++; if ({m0_ack, m0_err, s_cyc, s_stb} !== 4'b0000) begin failures++;
      $display("FAIL abort_drop: got ack/err/cyc/stb=%b expected 0000", {m0_ack, m0_err, s_cyc, s_stb}); end
    next_cycle();
    s_ack = 1; s_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || m0_ack !== 1'b0 || m0_rdata !== 32'h0) begin failures++;
      $display("FAIL abort_late_ack: got grant=%b ack=%b rdata=%h expected 00/0/0", grant, m0_ack, m0_rdata); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid_transfer();
    apply_reset();
    m1_cyc = 1; m1_stb = 1; m1_addr = 32'h500;
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin failures++;
      $display("FAIL rst_mid_own1: got %b expected 10", grant); end
    #1;
    rst_n = 1'b0;
    s_ack = 1; s_rdata = 32'h7777_7777;
    #1;
    checks++; if ({grant, s_cyc, s_stb, m1_ack, dbg_state} !== 7'd0 || s_addr !== 32'h0 || m1_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_mid_async: got grant=%b stb=%b ack=%b state=%0d", grant, s_stb, m1_ack, dbg_state); end
    next_cycle();
    rst_n = 1'b1;
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h600;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || m1_ack !== 1'b0 || m0_ack !== 1'b0) begin failures++;
      $display("FAIL rst_pending_ack: got grant=%b m0_ack=%b m1_ack=%b expected 00/0/0", grant, m0_ack, m1_ack); end
    next_cycle();
    s_ack = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b01) begin failures++;
      $display("FAIL rst_first_tie: got %b expected 01", grant); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_ack_beats_timeout();
    test_abort();
    test_reset_mid_transfer();
    repeat (2) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
